// File: rtl/keypad_debounce.sv
// Keypad front end: synchronises and debounces ten raw digit lines and emits one
// registered one-hot pulse per accepted keystroke. Multi-key presses are rejected.
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:9]  tecla,
  output logic [0:9]  IO,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, FIRE, HOLD, RELEASE, LOCK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_d;
  logic [0:9]       sync1, ks;
  logic [0:9]       cap, cap_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             any_key, one_hot;

  function automatic logic [3:0] digit_of(input logic [0:9] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++)
      if (v[i]) d = 4'(i);
    return d;
  endfunction

  assign any_key = |ks;
  assign one_hot = any_key && ((ks & (ks - 10'd1)) == 10'd0);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= tecla;
      ks    <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cap   <= cap_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    cap_d   = cap;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (one_hot) begin
          cap_d   = ks;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else if (any_key) begin
          state_d = LOCK;
        end
      end
      DEBOUNCE: begin
        if (ks != cap)             state_d = IDLE;
        else if (cnt == CNT_LAST)  state_d = FIRE;
        else                       cnt_d   = cnt + CNT_W'(1);
      end
      FIRE: state_d = HOLD;
      HOLD, LOCK: begin
        if (!any_key) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (any_key)               state_d = HOLD;
        else if (cnt == CNT_LAST)  state_d = IDLE;
        else                       cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with the FIRE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IO        <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      IO        <= (state_d == FIRE) ? cap : '0;
      key_valid <= (state_d == FIRE);
      busy      <= (state_d != IDLE);
      if (state_d == FIRE) key_code <= digit_of(cap);
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with a short debounce window (4 cycles).
module tb_keypad_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:9] tecla;
  logic [0:9] IO;
  logic [3:0] key_code;
  logic       key_valid;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int kv_bad      = 0;
  int base;

  keypad_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .tecla(tecla), .IO(IO),
    .key_code(key_code), .key_valid(key_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count pulse cycles; a pulse wider than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (IO != 10'd0) pulses++;
    if (key_valid !== (IO != 10'd0)) kv_bad++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    tecla = 10'd0;
    tick(2);
    check("rst_io",    32'(IO),        32'd0);
    check("rst_code",  32'(key_code),  32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    reset = 1'b1;
    tick(2);

    // 1: single press of digit 7, held 30 cycles
    base = pulses;
    tecla = 10'b0000000100;
    tick(6);
    check("t1_early",  32'(IO),        32'd0);
    check("t1_busy",   32'(busy),      32'd1);
    tick(1);
    check("t1_io",     32'(IO),        32'(10'b0000000100));
    check("t1_valid",  32'(key_valid), 32'd1);
    check("t1_code",   32'(key_code),  32'd7);
    tick(1);
    check("t1_width",  32'(IO),        32'd0);
    tick(22);
    tecla = 10'd0;
    tick(6);
    check("t1_relbusy", 32'(busy),     32'd1);
    tick(1);
    check("t1_idle",   32'(busy),      32'd0);
    check("t1_pulses", 32'(pulses - base), 32'd1);

    // 2: digit 3 bounces 1,0,1,0 then stays
    base = pulses;
    tecla = 10'b0001000000; tick(1);
    tecla = 10'd0;          tick(1);
    tecla = 10'b0001000000; tick(1);
    tecla = 10'd0;          tick(1);
    tecla = 10'b0001000000;
    tick(6);
    check("t2_bounce", 32'(pulses - base), 32'd0);
    tick(1);
    check("t2_io",     32'(IO),        32'(10'b0001000000));
    check("t2_code",   32'(key_code),  32'd3);
    tecla = 10'd0;
    tick(10);

    // 3: digits 2 and 5 together are rejected
    base = pulses;
    tecla = 10'b0010010000;
    tick(20);
    check("t3_busy",   32'(busy),      32'd1);
    tecla = 10'd0;
    tick(6);
    check("t3_relbusy", 32'(busy),     32'd1);
    tick(1);
    check("t3_idle",   32'(busy),      32'd0);
    check("t3_pulses", 32'(pulses - base), 32'd0);
    check("t3_code",   32'(key_code),  32'd3);

    // 4: press 1, release, press 9, then a too-short release gap
    base = pulses;
    tecla = 10'b0100000000;
    tick(7);
    check("t4_io1",    32'(IO),        32'(10'b0100000000));
    check("t4_code1",  32'(key_code),  32'd1);
    tick(5);
    tecla = 10'd0;
    tick(10);
    tecla = 10'b0000000001;
    tick(7);
    check("t4_io9",    32'(IO),        32'(10'b0000000001));
    check("t4_code9",  32'(key_code),  32'd9);
    tick(5);
    tecla = 10'd0;
    tick(2);
    tecla = 10'b0000001000;
    tick(20);
    check("t4_gap",    32'(pulses - base), 32'd2);
    check("t4_gapcode", 32'(key_code), 32'd9);
    tecla = 10'd0;
    tick(10);

    // 5: reset during DEBOUNCE with digit 4 held through release
    base = pulses;
    tecla = 10'b0000100000;
    tick(4);
    reset = 1'b0;
    #1;
    check("t5_rst_io",   32'(IO),       32'd0);
    check("t5_rst_busy", 32'(busy),     32'd0);
    check("t5_rst_code", 32'(key_code), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(6);
    check("t5_nopulse", 32'(pulses - base), 32'd0);
    tick(1);
    check("t5_io",     32'(IO),        32'(10'b0000100000));
    check("t5_code",   32'(key_code),  32'd4);
    tecla = 10'd0;
    tick(10);

    // 6: digit 0 held 1000 cycles, no auto-repeat
    base = pulses;
    tecla = 10'b1000000000;
    tick(7);
    check("t6_io",     32'(IO),        32'(10'b1000000000));
    check("t6_code",   32'(key_code),  32'd0);
    tick(993);
    check("t6_pulses", 32'(pulses - base), 32'd1);
    tecla = 10'd0;
    tick(10);
    check("t6_idle",   32'(busy),      32'd0);

    check("valid_align", 32'(kv_bad),  32'd0);
    check("total_pulses", 32'(pulses), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
